// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store engine on a word-wide valid/ready bus; MEM_MISALIGNED_SPLIT_EN enables two-beat misaligned accesses.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_width,
  input  logic        req_sign_extend,
  input  logic        req_w_enable,
  input  logic [31:0] req_w_value,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_misaligned,
  output logic        rsp_bus_error,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata
);
  localparam logic [2:0] IDLE = 3'd0, REQ_LO = 3'd1, WAIT_LO = 3'd2, REQ_HI = 3'd3, WAIT_HI = 3'd4, DONE = 3'd5;
`ifdef MEM_MISALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif
  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d, wval_q, wval_d, lo_q, lo_d, hi_q, hi_d, cnt_q, cnt_d;
  logic [1:0]  width_q, width_d;
  logic        sext_q, sext_d, we_q, we_d, mis_q, mis_d, err_q, err_d;
  logic [1:0]  off;
  logic [3:0]  mask;
  logic [7:0]  strb8;
  logic [63:0] wdata64;
  logic [31:0] ld, ext;
  logic        split, hi_beat, mis_in, timed_out;
  always_comb begin
    off       = addr_q[1:0];
    mask      = width_q[1] ? 4'b1111 : width_q[0] ? 4'b0011 : 4'b0001;
    strb8     = {4'b0, mask} << off;
    wdata64   = {32'b0, wval_q} << {off, 3'b0};
    split     = SPLIT_EN && (|strb8[7:4]);
    hi_beat   = state_q == REQ_HI;
    ld        = 32'({hi_q, lo_q} >> {off, 3'b0});
    ext       = width_q[1] ? ld :
                width_q[0] ? {{16{sext_q & ld[15]}}, ld[15:0]} : {{24{sext_q & ld[7]}}, ld[7:0]};
    mis_in    = !SPLIT_EN && ((req_width == 2'd1 && req_addr[0]) || (req_width[1] && |req_addr[1:0]));
    // the final count cycle is still a valid response cycle; only its absence times out
    timed_out = (TIMEOUT_CYCLES > 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));
  end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wval_d  = wval_q;
    width_d = width_q;
    sext_d  = sext_q;
    we_d    = we_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d  = req_addr;
        wval_d  = req_w_value;
        width_d = req_width;
        sext_d  = req_sign_extend;
        we_d    = req_w_enable;
        lo_d    = '0;
        hi_d    = '0;
        mis_d   = mis_in;
        err_d   = 1'b0;
        state_d = mis_in ? DONE : REQ_LO;
      end
      REQ_LO, REQ_HI: if (bus_req_ready) begin
        state_d = state_q + 3'd1;
        cnt_d   = '0;
      end
      WAIT_LO: if (bus_rsp_valid) begin
        lo_d    = bus_rdata;
        state_d = split ? REQ_HI : DONE;
      end else if (timed_out) begin
        err_d   = 1'b1;
        state_d = DONE;
      end else cnt_d = cnt_q + 32'd1;
      WAIT_HI: if (bus_rsp_valid) begin
        hi_d    = bus_rdata;
        state_d = DONE;
      end else if (timed_out) begin
        err_d   = 1'b1;
        state_d = DONE;
      end else cnt_d = cnt_q + 32'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wval_q  <= '0;
      width_q <= '0;
      sext_q  <= 1'b0;
      we_q    <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wval_q  <= wval_d;
      width_q <= width_d;
      sext_q  <= sext_d;
      we_q    <= we_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    req_ready      = state_q == IDLE;
    rsp_valid      = state_q == DONE;
    rsp_misaligned = rsp_valid & mis_q;
    rsp_bus_error  = rsp_valid & err_q;
    rsp_data       = (rsp_valid && !we_q && !mis_q && !err_q) ? ext : 32'd0;
    bus_req_valid  = state_q == REQ_LO || state_q == REQ_HI;
    bus_we         = bus_req_valid & we_q;
    bus_addr       = {addr_q[31:2], 2'b00} + {29'd0, hi_beat, 2'b00};
    bus_wdata      = hi_beat ? wdata64[63:32] : wdata64[31:0];
    bus_wstrb      = bus_we ? (hi_beat ? strb8[7:4] : strb8[3:0]) : 4'b0000;
  end
endmodule
